// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: data widths, reset defaults, fetch
// state encodings, the fetch-queue entry layout and the fetch range check.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int              MEM_WORDS_DEFAULT = 1024;

  // Fetch state encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // Widened by one bit so the byte limit cannot overflow for large memories.
  function automatic logic pc_in_range(input logic [XLEN-1:0] pc,
                                       input int unsigned     mem_words);
    return {1'b0, pc} < (33'(mem_words) << 2);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-to-decode handshake: the fetch side presents {instr, pc} with
// out_valid, and decode accepts the head entry with out_ready.
interface imem_fetch_ctrl_if;
  import cpu_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;

  modport master (output out_valid, out_instr, out_pc, input out_ready);
  modport slave  (input out_valid, out_instr, out_pc, output out_ready);

endinterface

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// DEPTH-entry synchronous FIFO of {instr, pc}; a flush empties it in one
// cycle and a push is accepted while full when a pop happens the same cycle.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset only because the head must read as zero out
      // of reset; with a handful of entries this is cheap, unlike a RAM.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the combinational imem,
// queues {instr, pc} for decode, and handles redirect, halt and fetch faults.
module imem_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int              DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [XLEN-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]    imem_instr,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_target,
  imem_fetch_ctrl_if.master     dec,
  output logic                  fault,
  output logic [XLEN-1:0]       fault_pc,
  output logic [31:0]           issued_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [1:0]      state;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  fetch_entry_t    q_head;
  logic            pop;
  logic            can_fetch;
  logic            fetch;
  logic            oor_fault;
  logic            misalign_fault;

  assign imem_addr     = pc;
  assign fault         = (state == ST_FAULT);
  assign dec.out_valid = ~q_empty;
  assign dec.out_instr = q_head.instr;
  assign dec.out_pc    = q_head.pc;

  assign pop       = dec.out_valid & dec.out_ready;
  assign can_fetch = ~halt & ~fault & ~redirect_valid &
                     ((q_count < CW'(DEPTH)) | pop);
  // A fetch that would leave the memory becomes a fault instead of a push.
  assign fetch          = can_fetch &  pc_in_range(pc, MEM_WORDS);
  assign oor_fault      = can_fetch & ~pc_in_range(pc, MEM_WORDS);
  assign misalign_fault = redirect_valid & ~fault & (redirect_target[1:0] != 2'b00);

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (fetch),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data ('{instr: imem_instr, pc: pc}),
    .rd_data (q_head),
    .count   (q_count),
    .empty   (q_empty)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      state        <= ST_RUN;
      fault_pc     <= '0;
      issued_count <= '0;
    end else begin
      // Once faulted, redirects still flush the queue but no longer steer pc.
      if (redirect_valid && !fault) pc <= redirect_target;
      else if (fetch)               pc <= pc + 32'd4;

      if (misalign_fault)  fault_pc <= redirect_target;
      else if (oor_fault)  fault_pc <= pc;

      if (misalign_fault || oor_fault) state <= ST_FAULT;
      else if (state != ST_FAULT)      state <= halt ? ST_HALTED : ST_RUN;

      if (pop) issued_count <= issued_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a 1024-word instruction memory model
// with fixed contents, one task per scenario, hand-computed expectations.
module tb_imem_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] issued_count;

  logic [31:0] mem [1024];
  int          n_cmp = 0;
  int          n_bad = 0;

  imem_fetch_ctrl_if dif ();

  imem_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec             (dif),
    .fault           (fault),
    .fault_pc        (fault_pc),
    .issued_count    (issued_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32'h1000) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    dif.out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    dif.out_ready = 1'b1;
    tick();
    tick();
    cmp("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
    cmp("rst_out_instr", dif.out_instr, 32'd0);
    cmp("rst_out_pc", dif.out_pc, 32'd0);
    cmp("rst_fault", {31'd0, fault}, 32'd0);
    cmp("rst_fault_pc", fault_pc, 32'd0);
    cmp("rst_issued", issued_count, 32'd0);
    cmp("rst_imem_addr", imem_addr, 32'd0);
    reset = 1'b0;
    cmp("rel_valid_n1", {31'd0, dif.out_valid}, 32'd0);
    tick();
    cmp("rel_valid_n2", {31'd0, dif.out_valid}, 32'd1);
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [4];
    exp_w = '{32'hFC00_0003, 32'hFC20_0005, 32'hFC40_0006, 32'h0060_0824};
    for (int i = 0; i < 4; i++) begin
      cmp("stream_valid", {31'd0, dif.out_valid}, 32'd1);
      cmp("stream_pc", dif.out_pc, 32'(4 * i));
      cmp("stream_instr", dif.out_instr, exp_w[i]);
      cmp("stream_issued", issued_count, 32'(i));
      tick();
    end
    cmp("stream_issued_end", issued_count, 32'd4);
    cmp("stream_next_pc", dif.out_pc, 32'h10);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [3];
    exp_w = '{32'hFC00_0003, 32'hFC20_0005, 32'hFC40_0006};
    do_reset();
    tick();
    dif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("bp_hold_valid", {31'd0, dif.out_valid}, 32'd1);
      cmp("bp_hold_pc", dif.out_pc, 32'd0);
      cmp("bp_hold_instr", dif.out_instr, 32'hFC00_0003);
    end
    cmp("bp_imem_addr", imem_addr, 32'd8);
    cmp("bp_issued_held", issued_count, 32'd0);
    dif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmp("bp_resume_valid", {31'd0, dif.out_valid}, 32'd1);
      cmp("bp_resume_pc", dif.out_pc, 32'(4 * i));
      cmp("bp_resume_instr", dif.out_instr, exp_w[i]);
      tick();
    end
    cmp("bp_issued", issued_count, 32'd3);
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    dif.out_ready = 1'b0;
    tick();
    dif.out_ready = 1'b1;
    tick();
    cmp("rd_head_pc", dif.out_pc, 32'd4);
    redirect_valid = 1'b1; redirect_target = 32'h14;
    tick();
    redirect_valid = 1'b0;
    cmp("rd_issued", issued_count, 32'd2);
    cmp("rd_flushed", {31'd0, dif.out_valid}, 32'd0);
    cmp("rd_imem_addr", imem_addr, 32'h14);
    tick();
    cmp("rd_valid", {31'd0, dif.out_valid}, 32'd1);
    cmp("rd_pc", dif.out_pc, 32'h14);
    cmp("rd_instr", dif.out_instr, 32'hA000_0005);
    tick();
    cmp("rd_next_pc", dif.out_pc, 32'h18);
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    dif.out_ready = 1'b0;
    tick();
    dif.out_ready = 1'b1;
    halt = 1'b1;
    tick();
    cmp("halt_valid1", {31'd0, dif.out_valid}, 32'd1);
    cmp("halt_pc1", dif.out_pc, 32'd4);
    cmp("halt_addr1", imem_addr, 32'd8);
    tick();
    cmp("halt_valid2", {31'd0, dif.out_valid}, 32'd0);
    cmp("halt_addr2", imem_addr, 32'd8);
    tick();
    cmp("halt_valid3", {31'd0, dif.out_valid}, 32'd0);
    cmp("halt_addr3", imem_addr, 32'd8);
    halt = 1'b0;
    tick();
    cmp("halt_resume_valid", {31'd0, dif.out_valid}, 32'd1);
    cmp("halt_resume_pc", dif.out_pc, 32'd8);
    cmp("halt_resume_instr", dif.out_instr, 32'hFC40_0006);
    cmp("halt_issued", issued_count, 32'd2);
  endtask

  task automatic test_misaligned();
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h6;
    tick();
    redirect_valid = 1'b0;
    cmp("mis_fault", {31'd0, fault}, 32'd1);
    cmp("mis_fault_pc", fault_pc, 32'h6);
    cmp("mis_valid", {31'd0, dif.out_valid}, 32'd0);
    cmp("mis_issued", issued_count, 32'd1);
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    cmp("mis_fault_pc_kept", fault_pc, 32'h6);
    cmp("mis_addr_kept", imem_addr, 32'h6);
    tick();
    cmp("mis_no_fetch", {31'd0, dif.out_valid}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("mis_rst_fault", {31'd0, fault}, 32'd0);
    cmp("mis_rst_fault_pc", fault_pc, 32'd0);
  endtask

  task automatic test_out_of_range();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFC;
    tick();
    redirect_valid = 1'b0;
    cmp("oor_valid0", {31'd0, dif.out_valid}, 32'd0);
    cmp("oor_addr0", imem_addr, 32'hFFC);
    tick();
    cmp("oor_last_valid", {31'd0, dif.out_valid}, 32'd1);
    cmp("oor_last_pc", dif.out_pc, 32'hFFC);
    cmp("oor_last_instr", dif.out_instr, 32'hA000_03FF);
    cmp("oor_no_fault_yet", {31'd0, fault}, 32'd0);
    cmp("oor_addr1", imem_addr, 32'h1000);
    tick();
    cmp("oor_fault", {31'd0, fault}, 32'd1);
    cmp("oor_fault_pc", fault_pc, 32'h1000);
    cmp("oor_valid_after", {31'd0, dif.out_valid}, 32'd0);
    cmp("oor_issued", issued_count, 32'd1);
    tick();
    cmp("oor_no_push", {31'd0, dif.out_valid}, 32'd0);
    cmp("oor_issued_stable", issued_count, 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 | 32'(k);
    mem[0] = 32'hFC00_0003;
    mem[1] = 32'hFC20_0005;
    mem[2] = 32'hFC40_0006;
    mem[3] = 32'h0060_0824;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_misaligned();
    test_out_of_range();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction fetch sequencer in front of the combinational-read instruction memory (1024 x 32-bit words, word index = byte address >> 2). It owns the PC, drives the memory address every cycle and captures each instruction with its PC into a small queue. The queue feeds decode through a valid/ready handshake. It also handles branch/jump redirects, external halt, and a sticky fault on a misaligned or out-of-range fetch.

Parameters:
RESET_PC, 32'h0, byte address fetched first after reset; must be 4-byte aligned
MEM_WORDS, 1024, instruction memory depth in words; the legal byte range is 0 .. MEM_WORDS*4-1
DEPTH, 2, fetch queue entries (power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous reset, active-high
imem_addr  out  32  byte address to instruction memory; combinational, always equals pc
imem_instr  in  32  instruction returned combinationally for imem_addr in the same cycle
halt  in  1  when high, fetch pauses; the queue keeps draining
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  32  new byte PC
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction
out_pc  out  32  head PC
fault  out  1  sticky fetch fault
fault_pc  out  32  offending PC, captured when the fault sets
issued_count  out  32  number of completed out handshakes; wraps at 2^32

Behaviour:
- Reset values (reset high at a clock edge):
  - pc=RESET_PC, queue empty.
  - out_valid=0, out_instr=0, out_pc=0.
  - fault=0, fault_pc=0, issued_count=0.
  - Reset overrides every other input.
- Handshake:
  - pop = out_valid & out_ready.
  - out_instr and out_pc hold steady while out_valid=1 and out_ready=0.
  - out_* are driven from queue registers, never directly from imem_instr.
- Fetch condition: fetch = !reset & !halt & !fault & !redirect_valid & in_range(pc) & (count<DEPTH | pop).
- On fetch, at the clock edge:
  - push {imem_instr, pc} to the queue tail;
  - pc <= pc+4 (32-bit wrap; in practice range-limited).
- Full queue:
  - If count==DEPTH and pop=0, there is no fetch and pc holds.
  - Push and pop in the same cycle while full is legal; count is unchanged.
- Empty queue: out_valid=0. A pushed entry becomes visible the next cycle; there is no same-cycle bypass.
- Latency: after reset release or a redirect, the first instruction appears on out_* 2 cycles later.
  - Cycle N: redirect (or reset) sampled.
  - Cycle N+1: fetch.
  - Cycle N+2: out_valid=1.
- Redirect (redirect_valid=1), at the edge:
  - A pop in the same cycle completes and counts in issued_count.
  - The whole queue is then flushed (count=0).
  - pc <= redirect_target.
  - There is no fetch in the redirect cycle.
  - Redirect has priority over halt.
- Misaligned redirect (redirect_target[1:0]!=0):
  - queue flushed;
  - fault<=1, fault_pc<=redirect_target;
  - pc <= redirect_target.
- Out of range: when fetch would otherwise occur and pc >= MEM_WORDS*4:
  - fault<=1, fault_pc<=pc;
  - no push; the queue still drains normally.
- Fault state:
  - Sticky until reset; no further fetch occurs.
  - Further redirects are ignored for pc and fault_pc but still flush the queue.
- halt: pc and queue contents are frozen except for pops. Deasserting halt resumes the fetch in that same cycle.
- issued_count increments by 1 on every pop.
- State machine (2-bit): RUN, HALTED, FAULT.
  - RUN→HALTED when halt=1.
  - HALTED→RUN when halt=0.
  - Any state→FAULT on a fault condition.
  - FAULT exits only via reset.
  - The state is internal; only fault is exported.

Decomposition:
- Shared package (cpu_pkg): XLEN=32, INSTR_W=32, RESET_PC default, MEM_WORDS default, fetch state enum {RUN, HALTED, FAULT}.
- One natural sub-module: fetch_queue, a DEPTH-entry synchronous FIFO of {instr, pc} with push/pop/flush, count, full/empty, and same-cycle push+pop when full. The PC, state machine and counter stay in imem_fetch_ctrl.

Test Plan:
- Reset released with out_ready=1 and the memory loaded with word0=FC000003, word1=FC200005, word2=FC400006, word3=00600824 → out_valid rises 2 cycles after release; then one handshake per cycle with (pc,instr) = (0,FC000003), (4,FC200005), (8,FC400006), (C,00600824); issued_count=4 after these four.
- out_ready=0 for 5 cycles after the first valid → queue fills to 2; pc holds at 8; imem_addr=8; out_instr stays FC000003. When out_ready returns to 1, order resumes 0,4,8 with no gap or duplicate.
- redirect_valid=1, target=0x14, in the same cycle as a pop of pc=4 → issued_count includes pc=4; the pc=8 entry is flushed; 2 cycles later out_pc=0x14 with the instr of word 5.
- halt=1 for 3 cycles with out_ready=1 → the queue drains to out_valid=0; imem_addr is constant. After halt=0, fetch resumes from the held pc.
- Redirect to target=0x6 → fault=1, fault_pc=6, out_valid=0 next cycle. A later redirect to 0x10 leaves fault_pc=6 and causes no fetch. Reset clears fault.
- Redirect to 0xFFC (last word) → one instruction issued at pc=0xFFC; then fault=1 with fault_pc=0x1000 and no further pushes.
